// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store sequencer sitting between decode/execute and a 32-bit data bus.
// A request carries the 3-bit mem_read / mem_write size codes from the
// control unit. The block checks legality and alignment, runs one bus beat
// (byte/half/word) or two beats (doubleword), and returns one response pulse
// with sign- or zero-extended load data. While it is busy it stalls the pipe.
//
// Optional build macro:
//   LSU_TIMEOUT_EN - abort a beat with a fault after TIMEOUT_CYCLES cycles
//                    without bus_ack. Left undefined, the block waits for
//                    bus_ack forever.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid        request present
//   req_ready        high only in IDLE; accept = req_valid & req_ready
//   mem_read[2:0]    001 LB, 010 LH, 011 LW, 100 LD, 101 LBU, 110 LHU, 111 LWU
//   mem_write[2:0]   001 SB, 010 SH, 011 SW, 100 SD; 101-111 illegal
//   addr[63:0]       byte address (truncated to ADDR_W bits on the bus)
//   wdata[63:0]      store data, LSB-justified
//   stall            high whenever the block is not IDLE
//   rsp_valid        one-cycle response pulse
//   rsp_rdata[63:0]  extended load data; 0 for stores and faults
//   rsp_fault        misaligned, illegal or timed-out op
//   bus_req          bus request, held until bus_ack
//   bus_we           1 = write
//   bus_addr         word-aligned bus address
//   bus_wdata[31:0]  lane-replicated write data
//   bus_be[3:0]      byte enables
//   bus_ack          beat complete; bus_rdata valid in the same cycle
//   bus_rdata[31:0]  read data
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        mem_read,
  input  logic [2:0]        mem_write,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_n;

  logic [2:0]  op_read, op_write;
  logic [1:0]  op_lane;
  logic [31:0] op_wdata_hi;
  logic [31:0] lo_word;

  logic              bus_req_n, bus_we_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [31:0]       bus_wdata_n;
  logic [3:0]        bus_be_n;
  logic              rsp_valid_n, rsp_fault_n;
  logic [63:0]       rsp_rdata_n;

  logic        accept, ack, op_dbl;
  logic [2:0]  code;
  logic        is_byte, is_half, is_word, is_dbl;
  logic        illegal, misaligned, noop;
  logic [3:0]  be_acc;
  logic [31:0] wd_acc;
  logic [31:0] ld_shift;
  logic [63:0] ld_ext;
  logic        tmo_hit;

  // The upper address bits above the bus width are deliberately dropped;
  // folding them here keeps them visibly consumed.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign accept    = req_valid & req_ready;
  // An ack only counts while we are actually requesting the bus.
  assign ack       = bus_ack & bus_req;
  assign op_dbl    = (op_read == 3'b100) || (op_write == 3'b100);

  // Decode the incoming request: operand size from whichever code is set,
  // plus the illegal / misaligned / no-op classification used on accept.
  always_comb begin
    code       = mem_read | mem_write;
    is_byte    = (code[1:0] == 2'b01);
    is_half    = (code[1:0] == 2'b10);
    is_word    = (code[1:0] == 2'b11);
    is_dbl     = (code == 3'b100);
    illegal    = ((mem_read != 3'b000) && (mem_write != 3'b000)) ||
                 (mem_write[2] && (mem_write[1:0] != 2'b00));
    misaligned = (is_half && addr[0]) ||
                 (is_word && (addr[1:0] != 2'b00)) ||
                 (is_dbl  && (addr[2:0] != 3'b000));
    noop       = (mem_read == 3'b000) && (mem_write == 3'b000);
    be_acc     = 4'b1111;
    wd_acc     = wdata[31:0];
    if (is_byte) begin
      be_acc = 4'b0001 << addr[1:0];
      wd_acc = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_acc = 4'b0011 << addr[1:0];
      wd_acc = {2{wdata[15:0]}};
    end
  end

  // Load extension for single-beat reads: shift the addressed lane down to
  // bit 0, then sign- or zero-extend according to the read code.
  always_comb begin
    ld_shift = bus_rdata >> {op_lane, 3'b000};
    case (op_read)
      3'b001:  ld_ext = {{56{ld_shift[7]}}, ld_shift[7:0]};
      3'b010:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b011:  ld_ext = {{32{ld_shift[31]}}, ld_shift};
      3'b101:  ld_ext = {56'd0, ld_shift[7:0]};
      3'b110:  ld_ext = {48'd0, ld_shift[15:0]};
      3'b111:  ld_ext = {32'd0, ld_shift};
      default: ld_ext = 64'd0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;

  // The counter restarts on every beat entry (anything but a stay in a
  // beat state resets it) and counts cycles spent waiting for an ack.
  always_comb begin
    tmo_cnt_n = '0;
    if (((state == BEAT0) || (state == BEAT1)) && !ack) begin
      tmo_cnt_n = tmo_cnt + 1'b1;
    end
  end

  // The limit is hit in the last waiting cycle, so bus_req is high for
  // exactly TIMEOUT_CYCLES cycles; an ack in that cycle still wins.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
`endif

  // Next-state and next-output logic. Bus fields hold by default so they stay
  // stable while waiting for an ack; response fields default to zero so the
  // response is a single-cycle pulse.
  always_comb begin
    state_n     = state;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    bus_be_n    = bus_be;
    rsp_valid_n = 1'b0;
    rsp_fault_n = 1'b0;
    rsp_rdata_n = 64'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned || noop) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_fault_n = illegal || misaligned;
          end else begin
            state_n     = BEAT0;
            bus_req_n   = 1'b1;
            bus_we_n    = (mem_write != 3'b000);
            bus_addr_n  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_n    = be_acc;
            bus_wdata_n = (mem_write != 3'b000) ? wd_acc : 32'd0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (ack && (state == BEAT0) && op_dbl) begin
          state_n     = BEAT1;
          bus_addr_n  = bus_addr + ADDR_W'(4);
          bus_wdata_n = (op_write != 3'b000) ? op_wdata_hi : 32'd0;
        end else if (ack || tmo_hit) begin
          state_n     = RESP;
          bus_req_n   = 1'b0;
          bus_we_n    = 1'b0;
          bus_addr_n  = '0;
          bus_wdata_n = 32'd0;
          bus_be_n    = 4'd0;
          rsp_valid_n = 1'b1;
          rsp_fault_n = !ack;
          if (ack && (op_read != 3'b000)) begin
            rsp_rdata_n = op_dbl ? {bus_rdata, lo_word} : ld_ext;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered-output update; reset abandons any bus transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= 64'd0;
    end else begin
      state     <= state_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      bus_be    <= bus_be_n;
      rsp_valid <= rsp_valid_n;
      rsp_fault <= rsp_fault_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

  // Capture the request on accept so later input changes have no effect.
  // Only the pieces needed after the first beat is launched are kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_read     <= 3'd0;
      op_write    <= 3'd0;
      op_lane     <= 2'd0;
      op_wdata_hi <= 32'd0;
    end else if (accept) begin
      op_read     <= mem_read;
      op_write    <= mem_write;
      op_lane     <= addr[1:0];
      op_wdata_hi <= wdata[63:32];
    end
  end

  // The first beat of a doubleword load becomes the low word of the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_word <= 32'd0;
    end else if ((state == BEAT0) && ack) begin
      lo_word <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Directed bench for lsu_ctrl. Each operation pushes its expected response
// and expected bus beats into scoreboard queues; a bus responder with a
// programmable ack delay logs the beats it acknowledges and flags any change
// of the bus fields while a request is pending.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct packed {
    logic [63:0] data;
    logic        fault;
    logic [7:0]  lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  mem_read = 3'd0;
  logic [2:0]  mem_write = 3'd0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic        stall;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int          n_vec = 0;
  int          n_err = 0;
  int          ack_wait = 0;
  int          ack_cnt = 0;
  int          stab_err = 0;
  logic        spur_ack = 1'b0;
  logic        held = 1'b0;
  txn_t        held_fields;

  logic [31:0] rd_q[$];
  txn_t        exp_bus[$];
  txn_t        obs_bus[$];
  rsp_t        sb[$];

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Bus responder: acks after ack_wait idle cycles of bus_req, supplies read
  // data from rd_q, logs acked beats and checks field stability while held.
  always @(negedge clk) begin
    txn_t t;
    bus_ack = 1'b0;
    if (bus_req) begin
      t = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, be: bus_be};
      if (held && (t !== held_fields)) stab_err++;
      held_fields = t;
      if (ack_cnt >= ack_wait) begin
        bus_ack = 1'b1;
        if (rd_q.size() > 0) bus_rdata = rd_q.pop_front();
        else bus_rdata = 32'd0;
        obs_bus.push_back(t);
        ack_cnt = 0;
        held = 1'b0;
      end else begin
        ack_cnt++;
        held = 1'b1;
      end
    end else begin
      ack_cnt = 0;
      held = 1'b0;
      bus_ack = spur_ack;
    end
  end

  // One comparison: counts it, and reports a miscompare through an assertion.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge, hold it through the accept edge, then
  // scramble the inputs so any late sampling shows up as a wrong result.
  task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr,
                               input logic [63:0] a, input logic [63:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_read  = 3'($urandom);
    mem_write = 3'($urandom);
    addr      = {$urandom, $urandom};
    wdata     = {$urandom, $urandom};
  endtask

  task automatic pushTxn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    exp_bus.push_back('{we: we, addr: a, wdata: wd, be: be});
  endtask

  // Compare logged bus beats against the expected ones, then clear both.
  task automatic checkBus(input string tag);
    txn_t e, o;
    checkOutput({tag, " beats"}, 64'(obs_bus.size()), 64'(exp_bus.size()));
    while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = obs_bus.pop_front();
      checkOutput({tag, " bus_addr"}, 64'(o.addr), 64'(e.addr));
      checkOutput({tag, " bus_be"}, 64'(o.be), 64'(e.be));
      checkOutput({tag, " bus_we"}, 64'(o.we), 64'(e.we));
      if (e.we) checkOutput({tag, " bus_wdata"}, 64'(o.wdata), 64'(e.wdata));
    end
    exp_bus.delete();
    obs_bus.delete();
  endtask

  // Wait (bounded) for the response pulse, measuring latency from the accept
  // edge, and compare it with the scoreboard head.
  task automatic waitResponse(input string tag);
    int   lat;
    bit   seen;
    bit   busy_ok;
    rsp_t e;
    lat = 1;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (!(stall && !req_ready)) busy_ok = 1'b0;
        @(posedge clk);
        lat++;
      end
    end
    checkOutput({tag, " rsp_valid seen"}, 64'(seen), 64'd1);
    checkOutput({tag, " stall while busy"}, 64'(busy_ok), 64'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, " scoreboard entry"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, e.data);
        checkOutput({tag, " rsp_fault"}, 64'(rsp_fault), 64'(e.fault));
        checkOutput({tag, " latency"}, 64'(lat), 64'(e.lat));
        checkOutput({tag, " busy in RESP"}, 64'({stall, req_ready}), 64'b10);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " idle after RESP"}, 64'({rsp_valid, req_ready, stall}), 64'b010);
      end
    end
    checkBus(tag);
  endtask

  task automatic runOp(input string tag, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_data, input logic exp_fault, input int exp_lat);
    sb.push_back('{data: exp_data, fault: exp_fault, lat: 8'(exp_lat)});
    applyStimulus(rd, wr, a, wd);
    waitResponse(tag);
  endtask

  initial begin
    int   guard;
    bit   quiet;
    $display("[TB] start");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready/stall/valid", 64'({req_ready, stall, rsp_valid, rsp_fault}), 64'b1000);
    checkOutput("reset bus_req/we/be", 64'({bus_req, bus_we, bus_be}), 64'd0);
    checkOutput("reset bus_addr", 64'(bus_addr), 64'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;

    // Single-beat loads, zero-wait ack: response two cycles after accept.
    ack_wait = 0;
    rd_q.push_back(32'h80FFFFFF); pushTxn(1'b0, 32'h1000, 32'h0, 4'b1000);
    runOp("LB 0x1003", 3'b001, 3'b000, 64'h1003, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2);
    rd_q.push_back(32'hBEEF1234); pushTxn(1'b0, 32'h2000, 32'h0, 4'b1100);
    runOp("LHU 0x2002", 3'b110, 3'b000, 64'h2002, 64'h0, 64'h000000000000BEEF, 1'b0, 2);
    rd_q.push_back(32'hBEEF1234); pushTxn(1'b0, 32'h2000, 32'h0, 4'b1100);
    runOp("LH 0x2002", 3'b010, 3'b000, 64'h2002, 64'h0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 2);
    rd_q.push_back(32'h00018000); pushTxn(1'b0, 32'h5000, 32'h0, 4'b0011);
    runOp("LH 0x5000", 3'b010, 3'b000, 64'h5000, 64'h0, 64'hFFFFFFFFFFFF8000, 1'b0, 2);
    rd_q.push_back(32'h1122AB44); pushTxn(1'b0, 32'h5000, 32'h0, 4'b0010);
    runOp("LBU 0x5001", 3'b101, 3'b000, 64'h5001, 64'h0, 64'h00000000000000AB, 1'b0, 2);
    rd_q.push_back(32'h1122AB44); pushTxn(1'b0, 32'h5000, 32'h0, 4'b0001);
    runOp("LB 0x5000", 3'b001, 3'b000, 64'h5000, 64'h0, 64'h0000000000000044, 1'b0, 2);

    // Word loads with one wait cycle, including address truncation.
    ack_wait = 1;
    rd_q.push_back(32'h87654321); pushTxn(1'b0, 32'h4010, 32'h0, 4'b1111);
    runOp("LW 0x4010", 3'b011, 3'b000, 64'h4010, 64'h0, 64'hFFFFFFFF87654321, 1'b0, 3);
    rd_q.push_back(32'h87654321); pushTxn(1'b0, 32'h4014, 32'h0, 4'b1111);
    runOp("LWU 0x4014", 3'b111, 3'b000, 64'h4014, 64'h0, 64'h0000000087654321, 1'b0, 3);
    rd_q.push_back(32'h00000001); pushTxn(1'b0, 32'h00000020, 32'h0, 4'b1111);
    runOp("LW truncated addr", 3'b011, 3'b000, 64'h0000000100000020, 64'h0, 64'h1, 1'b0, 3);

    // Stores: lane replication and byte enables.
    ack_wait = 0;
    pushTxn(1'b1, 32'h6000, 32'h5A5A5A5A, 4'b0100);
    runOp("SB 0x6002", 3'b000, 3'b001, 64'h6002, 64'hFFFFFFFFFFFFFF5A, 64'h0, 1'b0, 2);
    pushTxn(1'b1, 32'h6000, 32'hCAFECAFE, 4'b1100);
    runOp("SH 0x6002", 3'b000, 3'b010, 64'h6002, 64'h000000000000CAFE, 64'h0, 1'b0, 2);
    pushTxn(1'b1, 32'h6004, 32'hDEADBEEF, 4'b1111);
    runOp("SW 0x6004", 3'b000, 3'b011, 64'h6004, 64'h12345678DEADBEEF, 64'h0, 1'b0, 2);

    // Two-beat transfers with delayed acks.
    ack_wait = 2;
    pushTxn(1'b1, 32'h3000, 32'h55667788, 4'b1111);
    pushTxn(1'b1, 32'h3004, 32'h11223344, 4'b1111);
    runOp("SD 0x3000", 3'b000, 3'b100, 64'h3000, 64'h1122334455667788, 64'h0, 1'b0, 7);
    ack_wait = 1;
    rd_q.push_back(32'h33333333); rd_q.push_back(32'h44444444);
    pushTxn(1'b0, 32'h7008, 32'h0, 4'b1111);
    pushTxn(1'b0, 32'h700C, 32'h0, 4'b1111);
    runOp("LD 0x7008", 3'b100, 3'b000, 64'h7008, 64'h0, 64'h4444444433333333, 1'b0, 5);

    // Faults and no-op: response one cycle after accept, no bus beats.
    ack_wait = 0;
    runOp("LW misaligned", 3'b011, 3'b000, 64'h4002, 64'h0, 64'h0, 1'b1, 1);
    runOp("SW with LB", 3'b001, 3'b011, 64'h6000, 64'h0, 64'h0, 1'b1, 1);
    runOp("write code 101", 3'b000, 3'b101, 64'h6000, 64'h0, 64'h0, 1'b1, 1);
    runOp("LD misaligned", 3'b100, 3'b000, 64'h7004, 64'h0, 64'h0, 1'b1, 1);
    runOp("SH misaligned", 3'b000, 3'b010, 64'h6001, 64'h0, 64'h0, 1'b1, 1);
    runOp("LHU misaligned", 3'b110, 3'b000, 64'h2001, 64'h0, 64'h0, 1'b1, 1);
    runOp("no-op", 3'b000, 3'b000, 64'h1234, 64'h0, 64'h0, 1'b0, 1);

    // A stray ack while idle must be ignored.
    spur_ack = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || bus_req || !req_ready) quiet = 1'b0;
    end
    spur_ack = 1'b0;
    checkOutput("spurious ack ignored", 64'(quiet), 64'd1);

    // Reset in the second beat of a doubleword load abandons it silently.
    ack_wait = 3;
    rd_q.push_back(32'hAAAA5555);
    pushTxn(1'b0, 32'h8000, 32'h0, 4'b1111);
    applyStimulus(3'b100, 3'b000, 64'h8000, 64'h0);
    guard = 0;
    while (obs_bus.size() < 1 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("LD beat0 acked before reset", 64'(obs_bus.size()), 64'd1);
    @(negedge clk);
    checkOutput("LD in beat1 before reset", 64'({bus_req, bus_addr}), {31'd0, 1'b1, 32'h8004});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset mid-LD outputs", 64'({req_ready, stall, bus_req, rsp_valid}), 64'b1000);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || bus_req) quiet = 1'b0;
    end
    checkOutput("no response after reset", 64'(quiet), 64'd1);
    checkBus("LD reset");
    rd_q.delete();

    // Normal operation resumes after the abandoned transfer.
    ack_wait = 0;
    rd_q.push_back(32'hFEDCBA98); pushTxn(1'b0, 32'h9000, 32'h0, 4'b1111);
    runOp("LWU after reset", 3'b111, 3'b000, 64'h9000, 64'h0, 64'h00000000FEDCBA98, 1'b0, 2);

    checkOutput("bus fields stable while held", 64'(stab_err), 64'd0);
    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the decode/execute stage and a 32-bit data-memory bus on the RV64 core. Accepts one memory op per request, using the 3-bit MemRead/MemWrite size codes from the control unit, and checks alignment. It drives single-beat (byte/half/word) or two-beat (doubleword) bus transactions, then returns sign- or zero-extended load data. It also asserts a pipeline stall while busy.

Parameters:
ADDR_W, 32, bus byte-address width; request address is truncated to ADDR_W bits
TIMEOUT_CYCLES, 255, cycles per beat without bus_ack before abort; used only with LSU_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
mem_read  in  3  001 LB, 010 LH, 011 LW, 100 LD, 101 LBU, 110 LHU, 111 LWU, 000 none
mem_write  in  3  001 SB, 010 SH, 011 SW, 100 SD, 000 none; 101-111 illegal
addr  in  64  byte address
wdata  in  64  store data, LSB-justified
stall  out  1  state != IDLE
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  64  extended load data; 0 for stores and faults
rsp_fault  out  1  misaligned, illegal or timed-out op
bus_req  out  1  transaction request; held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
bus_wdata  out  32  lane-replicated write data
bus_be  out  4  byte enables
bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle
bus_rdata  in  32  read data

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP. All outputs are registered except req_ready and stall.
- Reset (rst sampled high on clk edge, any state) -> IDLE. Outputs reset to 0, except req_ready = 1. Any in-flight bus transaction is abandoned and no response is issued.
- On accept, register mem_read, mem_write, addr and wdata. Input changes afterwards are ignored.
- Classification on accept:
  - mem_read and mem_write both nonzero, or mem_write in 101-111 -> RESP with fault.
  - Misalignment -> RESP with fault, no bus activity: half ops with addr[0] set; word ops with addr[1:0] != 0; LD/SD with addr[2:0] != 0.
  - Both codes 000 -> RESP, no fault, rdata 0.
  - Otherwise -> BEAT0.
- BEAT0:
  - bus_addr = {addr[ADDR_W-1:2], 00}.
  - SB: bus_be = 0001 << addr[1:0], bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_be = 0011 << addr[1:0], bus_wdata = {2{wdata[15:0]}}.
  - SW/SD: bus_be = 1111, bus_wdata = wdata[31:0].
  - Reads use the same be pattern; LW/LD use 1111.
- bus_req, bus_we, bus_addr, bus_be and bus_wdata stay stable from assertion until the cycle bus_ack is sampled. bus_ack while bus_req is low is ignored.
- On ack in BEAT0:
  - LD/SD -> BEAT1, with bus_addr + 4; SD drives wdata[63:32]. Beat-0 read data is held as the low word.
  - Otherwise -> RESP.
- On ack in BEAT1 -> RESP.
- bus_req drops on the edge after ack, except on the BEAT0 -> BEAT1 transition, where it stays high with the new address.
- Load extension: select the lane by addr[1:0]. LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend. LD = {beat1, beat0}.
- RESP lasts exactly 1 cycle, with rsp_valid = 1; then IDLE, and req_ready returns to 1 in the following cycle. No back-to-back accept in the RESP cycle.
- Latency: accept at cycle N; BEAT0 bus_req at N+1. With zero-wait ack, single beat gives rsp_valid at N+2; LD/SD at N+3. Fault/no-op: rsp_valid at N+1.

Optional Feature:
LSU_TIMEOUT_EN:
- When defined: an 8+ bit counter clears on entering BEAT0/BEAT1 and increments each cycle without ack. On reaching TIMEOUT_CYCLES, drop bus_req and go to RESP with rsp_fault = 1 and rsp_rdata = 0. An ack in the same cycle as the limit wins, giving a normal completion.
- When undefined: no counter; the block waits for bus_ack indefinitely.

Test Plan:
- LB, addr 0x1003, bus_rdata 0x80FFFFFF, ack immediately -> bus_addr 0x1000, be 1000; rsp_rdata 0xFFFFFFFFFFFFFF80; rsp_valid 2 cycles after accept.
- LHU, addr 0x2002, bus_rdata 0xBEEF1234 -> rsp_rdata 0x000000000000BEEF. Repeat with LH -> 0xFFFFFFFFFFFFBEEF.
- SD, addr 0x3000, wdata 0x1122334455667788, ack delayed 2 cycles per beat -> beat0 0x3000/0x55667788, beat1 0x3004/0x11223344, be 1111 both; stall high throughout; rsp_fault 0.
- LW at 0x4002 -> no bus_req; rsp_valid at N+1 with rsp_fault 1. SW request with mem_read also = 001 -> fault.
- rst asserted during BEAT1 of LD -> next cycle IDLE, bus_req 0, no rsp_valid, req_ready 1.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> bus_req dropped after 4 cycles; rsp_fault 1; rsp_rdata 0.
